// File: rtl/uart_alu_frame_ctrl.sv
// rtl/uart_alu_frame_ctrl.sv - UART byte-stream to ALU frame assembler and result serialiser
module uart_alu_frame_ctrl #(
    parameter int LEN_DATA    = 8,
    parameter int N_BYTES     = 2,
    parameter int LEN_OP      = 6,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         rx_done_tick,
    input  logic [LEN_DATA-1:0]          rx_data_in,
    input  logic                         tx_done_tick,
    input  logic [N_BYTES*LEN_DATA-1:0]  alu_result,
    output logic [N_BYTES*LEN_DATA-1:0]  A,
    output logic [N_BYTES*LEN_DATA-1:0]  B,
    output logic [LEN_OP-1:0]            OPCODE,
    output logic                         tx_start,
    output logic [LEN_DATA-1:0]          tx_data,
    output logic                         busy,
    output logic                         frame_err,
    output logic                         rx_overrun
);

    localparam int W     = N_BYTES * LEN_DATA;
    localparam int IDX_W = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BYTES - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    localparam logic [2:0] RX_A    = 3'd0;
    localparam logic [2:0] RX_B    = 3'd1;
    localparam logic [2:0] RX_OP   = 3'd2;
    localparam logic [2:0] EXEC    = 3'd3;
    localparam logic [2:0] TX_LOAD = 3'd4;
    localparam logic [2:0] TX_WAIT = 3'd5;

    logic [2:0]       state;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] k;
    logic [CNT_W-1:0] cnt;
    logic [W-1:0]     shadow_a;
    logic [W-1:0]     shadow_b;
    logic [W-1:0]     res_sr;
    logic             partial;
    logic             timeout;

    assign busy    = (state == EXEC) || (state == TX_LOAD) || (state == TX_WAIT);
    assign partial = ((state == RX_A) && (idx != '0)) || (state == RX_B) || (state == RX_OP);
    // An arriving byte always beats an expiring counter in the same cycle.
    assign timeout = (TIMEOUT_CYC != 0) && partial && !rx_done_tick && (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= RX_A;
            idx        <= '0;
            k          <= '0;
            cnt        <= '0;
            shadow_a   <= '0;
            shadow_b   <= '0;
            res_sr     <= '0;
            A          <= '0;
            B          <= '0;
            OPCODE     <= '0;
            tx_start   <= 1'b0;
            tx_data    <= '0;
            frame_err  <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            tx_start   <= 1'b0;
            frame_err  <= 1'b0;
            rx_overrun <= busy && rx_done_tick;

            if ((TIMEOUT_CYC == 0) || rx_done_tick || !partial || timeout)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;

            if (timeout) begin
                shadow_a  <= '0;
                shadow_b  <= '0;
                idx       <= '0;
                state     <= RX_A;
                frame_err <= 1'b1;
            end else begin
                case (state)
                    RX_A: begin
                        if (rx_done_tick) begin
                            shadow_a[idx*LEN_DATA +: LEN_DATA] <= rx_data_in;
                            if (idx == LAST_IDX) begin
                                idx   <= '0;
                                state <= RX_B;
                            end else begin
                                idx <= idx + 1'b1;
                            end
                        end
                    end
                    RX_B: begin
                        if (rx_done_tick) begin
                            shadow_b[idx*LEN_DATA +: LEN_DATA] <= rx_data_in;
                            if (idx == LAST_IDX) begin
                                idx   <= '0;
                                state <= RX_OP;
                            end else begin
                                idx <= idx + 1'b1;
                            end
                        end
                    end
                    RX_OP: begin
                        if (rx_done_tick) begin
                            A      <= shadow_a;
                            B      <= shadow_b;
                            OPCODE <= rx_data_in[LEN_OP-1:0];
                            state  <= EXEC;
                        end
                    end
                    EXEC: begin
                        res_sr <= alu_result;
                        k      <= '0;
                        state  <= TX_LOAD;
                    end
                    TX_LOAD: begin
                        tx_data  <= res_sr[LEN_DATA-1:0];
                        tx_start <= 1'b1;
                        state    <= TX_WAIT;
                    end
                    TX_WAIT: begin
                        // A done pulse coincident with our own start belongs to a previous byte.
                        if (tx_done_tick && !tx_start) begin
                            if (k == LAST_IDX) begin
                                state <= RX_A;
                            end else begin
                                k      <= k + 1'b1;
                                res_sr <= res_sr >> LEN_DATA;
                                state  <= TX_LOAD;
                            end
                        end
                    end
                    default: state <= RX_A;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_alu_frame_ctrl.sv
// tb/tb_uart_alu_frame_ctrl.sv - randomized scoreboard bench for uart_alu_frame_ctrl
module tb_uart_alu_frame_ctrl;

    localparam int TO = 100;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_done_tick;
    logic [7:0]  rx_data_in;
    logic        tx_done_tick;
    logic [15:0] alu_result;
    logic [15:0] A;
    logic [15:0] B;
    logic [5:0]  OPCODE;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        busy;
    logic        frame_err;
    logic        rx_overrun;

    uart_alu_frame_ctrl #(
        .LEN_DATA(8), .N_BYTES(2), .LEN_OP(6), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .rx_done_tick(rx_done_tick), .rx_data_in(rx_data_in),
        .tx_done_tick(tx_done_tick), .alu_result(alu_result),
        .A(A), .B(B), .OPCODE(OPCODE),
        .tx_start(tx_start), .tx_data(tx_data), .busy(busy),
        .frame_err(frame_err), .rx_overrun(rx_overrun)
    );

    always #5 clk = ~clk;

    always_comb begin
        case (OPCODE)
            6'h20:   alu_result = A + B;
            6'h22:   alu_result = A - B;
            default: alu_result = A ^ B;
        endcase
    end

    int          n_cmp = 0;
    int          n_mis = 0;
    int          fe_cnt = 0;
    int          ov_cnt = 0;
    logic [7:0]  exp_q[$];
    logic [15:0] m_a = '0;
    logic [15:0] m_b = '0;
    logic [5:0]  m_op = '0;
    logic [5:0]  ops[3] = '{6'h20, 6'h22, 6'h26};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic [15:0] a, input logic [15:0] b, input logic [5:0] op);
        if (op == 6'h20)      return a + b;
        else if (op == 6'h22) return a - b;
        else                  return a ^ b;
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            if (frame_err)  fe_cnt++;
            if (rx_overrun) ov_cnt++;
            if (tx_start) begin
                check_eq("tx_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) check_eq("tx_data", tx_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        tx_done_tick = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start === 1'b1 && !reset) begin
                repeat ($urandom_range(4, 10)) @(negedge clk);
                tx_done_tick = 1'b1;
                @(negedge clk);
                tx_done_tick = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d);
        rx_data_in   = d;
        rx_done_tick = 1'b1;
        @(negedge clk);
        rx_done_tick = 1'b0;
    endtask

    // Sends one frame; returns at the negedge of the first tx_start cycle.
    task automatic send_frame(input logic [15:0] a, input logic [15:0] b, input logic [7:0] opb,
                              input int gap_max, input int gap0);
        logic [7:0]  bytes[4];
        logic [15:0] r;
        bytes = '{a[7:0], a[15:8], b[7:0], b[15:8]};
        for (int i = 0; i < 4; i++) begin
            send_byte(bytes[i]);
            if (i == 0 && gap0 >= 0) idle(gap0);
            else if (i < 3)          idle($urandom_range(0, gap_max));
        end
        check_eq("hold_a", A, m_a);
        check_eq("hold_b", B, m_b);
        check_eq("hold_op", OPCODE, m_op);
        send_byte(opb);
        m_a  = a;
        m_b  = b;
        m_op = opb[5:0];
        r    = model(a, b, m_op);
        exp_q.push_back(r[7:0]);
        exp_q.push_back(r[15:8]);
        check_eq("commit_a", A, m_a);
        check_eq("commit_b", B, m_b);
        check_eq("commit_op", OPCODE, m_op);
        check_eq("busy_exec", busy, 1);
        @(negedge clk);
        check_eq("start_early", tx_start, 0);
        @(negedge clk);
        check_eq("start_lat", tx_start, 1);
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy !== 1'b0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        check_eq("idle_bound", 32'(t < 500), 1);
        check_eq("q_drained", exp_q.size(), 0);
    endtask

    task automatic rand_frame(input int gap_max);
        send_frame(16'($urandom), 16'($urandom), {2'($urandom), ops[$urandom_range(0, 2)]}, gap_max, -1);
    endtask

    initial begin
        int fe0;
        int ov0;
        reset        = 1'b1;
        rx_done_tick = 1'b0;
        rx_data_in   = '0;
        idle(3);
        check_eq("rst_a", A, 0);
        check_eq("rst_b", B, 0);
        check_eq("rst_op", OPCODE, 0);
        check_eq("rst_start", tx_start, 0);
        check_eq("rst_txd", tx_data, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_ferr", frame_err, 0);
        check_eq("rst_ovr", rx_overrun, 0);
        reset = 1'b0;
        idle(2);

        send_frame(16'h1234, 16'h5678, 8'h20, 0, -1);
        wait_idle();

        repeat (12) begin
            rand_frame(5);
            wait_idle();
            idle($urandom_range(0, 3));
        end

        fe0 = fe_cnt;
        send_byte(8'h11);
        send_byte(8'h22);
        idle(TO);
        idle(3);
        check_eq("timeout_pulses", fe_cnt - fe0, 1);
        check_eq("timeout_hold_a", A, m_a);
        check_eq("timeout_hold_op", OPCODE, m_op);
        rand_frame(3);
        wait_idle();

        fe0 = fe_cnt;
        send_frame(16'($urandom), 16'($urandom), 8'h22, 2, TO - 1);
        wait_idle();
        check_eq("edge_no_ferr", fe_cnt - fe0, 0);

        ov0 = ov_cnt;
        rand_frame(2);
        repeat (3) send_byte(8'($urandom));
        wait_idle();
        idle(2);
        check_eq("overrun_pulses", ov_cnt - ov0, 3);
        rand_frame(2);
        wait_idle();

        rand_frame(2);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_eq("arst_a", A, 0);
        check_eq("arst_b", B, 0);
        check_eq("arst_op", OPCODE, 0);
        check_eq("arst_start", tx_start, 0);
        check_eq("arst_txd", tx_data, 0);
        check_eq("arst_busy", busy, 0);
        exp_q.delete();
        m_a  = '0;
        m_b  = '0;
        m_op = '0;
        @(negedge clk);
        reset = 1'b0;
        idle(20);
        rand_frame(2);
        wait_idle();

        rand_frame(1);
        wait_idle();
        rand_frame(0);
        wait_idle();

        idle(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
